// File: rtl/sobel_row_buffer.sv
// Three-row line buffer feeding the Sobel accelerator from word-addressed image memory.
// Owns the single memory port: row fetches into a rotating 3-slot buffer, result writes win arbitration.
module sobel_row_buffer #(
  parameter int WIDTH    = 352,
  parameter int HEIGHT   = 288,
  parameter int ADDR_W   = 16,
  parameter int OUT_BASE = WIDTH * HEIGHT / 4
) (
  input  logic              clk,
  input  logic              rst,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [31:0]       mem_do,
  output logic [31:0]       mem_di,
  output logic              mem_en,
  output logic              mem_we,
  input  logic              en,
  input  logic              we,
  input  logic [31:0]       di,
  output logic [31:0]       doa,
  output logic [31:0]       dob,
  output logic [31:0]       doc,
  output logic              row_cached,
  input  logic              finish
);

  localparam int W      = WIDTH / 4;
  localparam int COL_W  = (W > 1) ? $clog2(W) : 1;
  localparam int IDX_W  = $clog2(3 * W);
  localparam int ROW_W  = $clog2(HEIGHT + 1);
  localparam int WR_MAX = W * (HEIGHT - 2);
  localparam int WRC_W  = $clog2(WR_MAX + 1);
  // Output rows 0 and HEIGHT-1 have no full 3x3 neighbourhood, so results start at row 1.
  localparam logic [ADDR_W-1:0] WR_BASE = ADDR_W'(OUT_BASE + W);

  typedef enum logic [1:0] {FILL, READY, REFILL, DONE} state_t;

  state_t            state;
  logic [1:0]        top;
  logic [ROW_W-1:0]  rows_loaded;
  logic [COL_W-1:0]  rd_col;
  logic [WRC_W-1:0]  wr_cnt;
  logic [ADDR_W-1:0] fetch_addr;
  logic              iss_busy;
  logic [COL_W-1:0]  iss_col;
  logic [1:0]        iss_row;
  logic [IDX_W-1:0]  iss_idx;
  logic              iss_last;
  logic              cap_vld;
  logic [IDX_W-1:0]  cap_idx;
  logic              cap_last;
  logic [31:0]       buf_q [0:3*W-1];

  logic              wr_ok;
  logic              rd_ok;
  logic [1:0]        iss_slot;
  logic              iss_end;

  function automatic logic [IDX_W-1:0] slot_idx(input logic [1:0] slot, input logic [COL_W-1:0] col);
    return IDX_W'(slot) * IDX_W'(W) + IDX_W'(col);
  endfunction

  function automatic logic [1:0] slot_next(input logic [1:0] slot);
    return (slot == 2'd2) ? 2'd0 : slot + 2'd1;
  endfunction

  always_comb begin
    wr_ok    = en && we && (wr_cnt < WRC_W'(WR_MAX));
    rd_ok    = en && !we && row_cached;
    iss_slot = (state == FILL) ? iss_row : top;
    iss_end  = (iss_col == COL_W'(W - 1)) && ((state != FILL) || (iss_row == 2'd2));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= FILL;
      top         <= 2'd0;
      rows_loaded <= '0;
      rd_col      <= '0;
      wr_cnt      <= '0;
      fetch_addr  <= '0;
      iss_busy    <= 1'b1;
      iss_col     <= '0;
      iss_row     <= 2'd0;
      iss_idx     <= '0;
      iss_last    <= 1'b0;
      cap_vld     <= 1'b0;
      cap_idx     <= '0;
      cap_last    <= 1'b0;
      mem_addr    <= '0;
      mem_di      <= '0;
      mem_en      <= 1'b0;
      mem_we      <= 1'b0;
      doa         <= '0;
      dob         <= '0;
      doc         <= '0;
      row_cached  <= 1'b0;
    end else begin
      mem_en   <= 1'b0;
      mem_we   <= 1'b0;
      // Read data returns the cycle after the issue, so the capture tag trails the port by one.
      cap_vld  <= mem_en && !mem_we;
      cap_idx  <= iss_idx;
      cap_last <= iss_last;

      if (wr_ok) begin
        mem_en   <= 1'b1;
        mem_we   <= 1'b1;
        mem_addr <= WR_BASE + ADDR_W'(wr_cnt);
        mem_di   <= di;
        wr_cnt   <= wr_cnt + WRC_W'(1);
      end else if (iss_busy) begin
        mem_en     <= 1'b1;
        mem_addr   <= fetch_addr;
        fetch_addr <= fetch_addr + ADDR_W'(1);
        iss_idx    <= slot_idx(iss_slot, iss_col);
        iss_last   <= iss_end;
        if (iss_col == COL_W'(W - 1)) begin
          iss_col <= '0;
          iss_row <= iss_row + 2'd1;
        end else begin
          iss_col <= iss_col + COL_W'(1);
        end
        if (iss_end) iss_busy <= 1'b0;
      end

      if (cap_vld && cap_last && (state == FILL || state == REFILL)) begin
        if (state == REFILL) begin
          top         <= slot_next(top);
          rows_loaded <= rows_loaded + ROW_W'(1);
        end else begin
          rows_loaded <= ROW_W'(3);
        end
        state      <= READY;
        row_cached <= 1'b1;
      end

      if (rd_ok) begin
        doa <= buf_q[slot_idx(top, rd_col)];
        dob <= buf_q[slot_idx(slot_next(top), rd_col)];
        doc <= buf_q[slot_idx(slot_next(slot_next(top)), rd_col)];
        if (rd_col == COL_W'(W - 1)) begin
          rd_col     <= '0;
          row_cached <= 1'b0;
          if (rows_loaded == ROW_W'(HEIGHT)) begin
            state <= DONE;
          end else begin
            // Sequential fetch_addr already points at row rows_loaded; the oldest slot is replaced.
            state    <= REFILL;
            iss_busy <= 1'b1;
            iss_col  <= '0;
          end
        end else begin
          rd_col <= rd_col + COL_W'(1);
        end
      end

      if (finish) begin
        state      <= DONE;
        row_cached <= 1'b0;
        iss_busy   <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (cap_vld) buf_q[cap_idx] <= mem_do;
  end

endmodule
